stopwatch_ctrl: RTL and testbench

Control FSM and timebase for the stopwatch digit chain. It converts debounced start/stop and clear button levels into edge events and runs a prescaler that issues one-cycle increment pulses to the least-significant mod counter. It issues a synchronous clear to the chain and halts the chain when the most-significant counter rolls over. It sits between the button debouncers and the cascaded mod counters.

---
 rtl/stopwatch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and timebase.
// Turns debounced button levels into edge events, runs the tick prescaler,
// and drives clear/increment pulses into the cascaded digit counters.
// Optional lap-hold support is compiled in with `define STOPWATCH_LAP_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | stopped at zero, waiting for start; clear re-zeroes chain
// S_RUN      | prescaler counting, ticks issued to the digit chain
// S_PAUSED   | prescaler frozen mid-interval; start resumes, clear resets
// S_OVERFLOW | top digit rolled over; chain halted until clear
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic rollover_top,
`ifdef STOPWATCH_LAP_EN
  input  logic btn_lap,
  output logic lap_hold,
`endif
  output logic tick_inc,
  output logic cnt_clear,
  output logic running,
  output logic paused,
  output logic overflow
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_PAUSED   = 2'd2,
    S_OVERFLOW = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TICK_W-1:0] presc;
  logic [TICK_W-1:0] presc_nxt;
  logic              tick_nxt;
  logic              clr_nxt;
  logic              ss_q;
  logic              clr_q;
  logic              ss_evt;
  logic              clr_evt;

  // Button history; reset to 1 so a button held through reset is not an event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_q  <= 1'b1;
      clr_q <= 1'b1;
    end else begin
      ss_q  <= btn_start_stop;
      clr_q <= btn_clear;
    end
  end

  assign ss_evt  = btn_start_stop & ~ss_q;
  assign clr_evt = btn_clear & ~clr_q;

  // Next-state, prescaler and pulse decode
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tick_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_evt) begin
          clr_nxt = 1'b1;
        end else if (ss_evt) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // The prescaler advances on every RUN cycle, even when leaving RUN,
        // so a coincident terminal count still yields its tick.
        if (presc == PRESC_LAST) begin
          presc_nxt = '0;
          tick_nxt  = 1'b1;
        end else begin
          presc_nxt = presc + TICK_W'(1);
        end
        if (rollover_top) begin
          state_nxt = S_OVERFLOW;
        end else if (ss_evt) begin
          state_nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (clr_evt) begin
          clr_nxt   = 1'b1;
          presc_nxt = '0;
          state_nxt = S_IDLE;
        end else if (ss_evt) begin
          state_nxt = S_RUN;
        end
      end
      S_OVERFLOW: begin
        if (clr_evt) begin
          clr_nxt   = 1'b1;
          presc_nxt = '0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        presc_nxt = '0;
      end
    endcase
  end

  // State, prescaler and registered outputs; flags mirror the new state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      tick_inc  <= 1'b0;
      cnt_clear <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      tick_inc  <= tick_nxt;
      cnt_clear <= clr_nxt;
      running   <= (state_nxt == S_RUN);
      paused    <= (state_nxt == S_PAUSED);
      overflow  <= (state_nxt == S_OVERFLOW);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q;
  logic lap_evt;

  assign lap_evt = btn_lap & ~lap_q;

  // Lap toggles only while running; any return to IDLE drops the hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q    <= 1'b1;
      lap_hold <= 1'b0;
    end else begin
      lap_q <= btn_lap;
      if (state_nxt == S_IDLE) begin
        lap_hold <= 1'b0;
      end else if (state == S_RUN && lap_evt) begin
        lap_hold <= ~lap_hold;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;
  localparam int M_OVF  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_start_stop;
  logic btn_clear;
  logic rollover_top;
  logic tick_inc;
  logic cnt_clear;
  logic running;
  logic paused;
  logic overflow;
`ifdef STOPWATCH_LAP_EN
  logic btn_lap;
  logic lap_hold;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear(btn_clear),
    .rollover_top(rollover_top),
`ifdef STOPWATCH_LAP_EN
    .btn_lap(btn_lap),
    .lap_hold(lap_hold),
`endif
    .tick_inc(tick_inc),
    .cnt_clear(cnt_clear),
    .running(running),
    .paused(paused),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Behavioural model: mode, elapsed RUN cycles within the current interval
  int   m_mode  = M_IDLE;
  int   m_phase = 0;
  bit   m_tick  = 1'b0;
  bit   m_clr   = 1'b0;
  bit   m_lap   = 1'b0;
  bit   p_ss    = 1'b1;
  bit   p_clr   = 1'b1;
  bit   p_lap   = 1'b1;
  bit   e_ss, e_clr, e_lap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_phase = 0; m_tick = 0; m_clr = 0; m_lap = 0;
      p_ss = 1; p_clr = 1; p_lap = 1;
    end else begin
      e_ss  = btn_start_stop && !p_ss;
      e_clr = btn_clear && !p_clr;
      p_ss  = btn_start_stop;
      p_clr = btn_clear;
`ifdef STOPWATCH_LAP_EN
      e_lap = btn_lap && !p_lap;
      p_lap = btn_lap;
`else
      e_lap = 1'b0;
`endif
      m_tick = 0;
      m_clr  = 0;
      case (m_mode)
        M_IDLE: begin
          if (e_clr) m_clr = 1;
          else if (e_ss) m_mode = M_RUN;
        end
        M_RUN: begin
          m_phase = (m_phase + 1) % TD;
          if (m_phase == 0) m_tick = 1;
          if (e_lap) m_lap = !m_lap;
          if (rollover_top) m_mode = M_OVF;
          else if (e_ss) m_mode = M_PAUS;
        end
        default: begin
          if (e_clr) begin
            m_clr = 1; m_phase = 0; m_mode = M_IDLE; m_lap = 0;
          end else if (m_mode == M_PAUS && e_ss) begin
            m_mode = M_RUN;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      check("tick_inc", tick_inc, m_tick);
      check("cnt_clear", cnt_clear, m_clr);
      check("running", running, m_mode == M_RUN);
      check("paused", paused, m_mode == M_PAUS);
      check("overflow", overflow, m_mode == M_OVF);
`ifdef STOPWATCH_LAP_EN
      check("lap_hold", lap_hold, m_lap);
`endif
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_inc && n < 20);
  endtask

  int n;
  int ntick;

  initial begin
    btn_start_stop = 1'b1;
    btn_clear      = 1'b0;
    rollover_top   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap        = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Start held through reset release: no event
    ntick = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick_inc) ntick++;
    end
    check_int("held_reset_ticks", ntick, 0);
    check("held_reset_idle", running, 1'b0);
    btn_start_stop = 1'b0;
    @(negedge clk);

    // Start, first tick latency, held button gives one event only
    btn_start_stop = 1'b1;
    @(negedge clk);
    check("start_running", running, 1'b1);
    wait_tick(n);
    check_int("first_tick_latency", n, 4);
    repeat (6) @(negedge clk);
    check("held_still_running", running, 1'b1);
    check("held_not_paused", paused, 1'b0);
    btn_start_stop = 1'b0;

    // Pause two cycles into an interval, resume completes it
    wait_tick(n);
    @(negedge clk);
    btn_start_stop = 1'b1;
    @(negedge clk);
    check("pause_paused", paused, 1'b1);
    btn_start_stop = 1'b0;
    ntick = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick_inc) ntick++;
    end
    check_int("pause_no_ticks", ntick, 0);
    check("pause_held", paused, 1'b1);
    btn_start_stop = 1'b1;
    @(negedge clk);
    check("resume_running", running, 1'b1);
    check("resume_not_paused", paused, 1'b0);
    wait_tick(n);
    check_int("resume_tick_latency", n, 2);
    btn_start_stop = 1'b0;

    // Clear ignored in RUN; simultaneous start+clear in PAUSED clears
    btn_clear = 1'b1;
    @(negedge clk);
    check("run_clear_ignored", cnt_clear, 1'b0);
    btn_clear = 1'b0;
    @(negedge clk);
    btn_start_stop = 1'b1;
    @(negedge clk);
    btn_start_stop = 1'b0;
    check("pause2_paused", paused, 1'b1);
    @(negedge clk);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    @(negedge clk);
    check("both_cnt_clear", cnt_clear, 1'b1);
    check("both_idle_run", running, 1'b0);
    check("both_idle_pause", paused, 1'b0);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    @(negedge clk);
    check("clear_one_cycle", cnt_clear, 1'b0);
    repeat (5) @(negedge clk);
    check("stays_stopped", running, 1'b0);

    // Overflow halts the chain until clear
    btn_start_stop = 1'b1;
    @(negedge clk);
    btn_start_stop = 1'b0;
    repeat (2) @(negedge clk);
    rollover_top = 1'b1;
    @(negedge clk);
    rollover_top = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_not_running", running, 1'b0);
    ntick = 0;
    btn_start_stop = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tick_inc) ntick++;
    end
    btn_start_stop = 1'b0;
    check_int("ovf_no_ticks", ntick, 0);
    check("ovf_start_ignored", overflow, 1'b1);
    btn_clear = 1'b1;
    @(negedge clk);
    check("ovf_clear_pulse", cnt_clear, 1'b1);
    check("ovf_cleared", overflow, 1'b0);
    btn_clear = 1'b0;
    @(negedge clk);

    // Reset mid-interval, then fresh start counts a full interval
    btn_start_stop = 1'b1;
    @(negedge clk);
    btn_start_stop = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_tick", tick_inc, 1'b0);
    check("rst_clear", cnt_clear, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_paused", paused, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    btn_start_stop = 1'b1;
    @(negedge clk);
    check("post_rst_running", running, 1'b1);
    wait_tick(n);
    check_int("post_rst_tick_latency", n, 4);
    btn_start_stop = 1'b0;
    @(negedge clk);

`ifdef STOPWATCH_LAP_EN
    // Two lap presses in RUN toggle the hold while ticks continue
    ntick = 0;
    btn_lap = 1'b1;
    @(negedge clk);
    check("lap_on", lap_hold, 1'b1);
    btn_lap = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tick_inc) ntick++;
    end
    btn_lap = 1'b1;
    @(negedge clk);
    check("lap_off", lap_hold, 1'b0);
    btn_lap = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tick_inc) ntick++;
    end
    check_int("lap_ticks_continue", ntick >= 2, 1);
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) btn_start_stop = ~btn_start_stop;
      if ($urandom_range(0, 19) == 0) btn_clear = ~btn_clear;
      rollover_top = ($urandom_range(0, 60) == 0);
`ifdef STOPWATCH_LAP_EN
      if ($urandom_range(0, 7) == 0) btn_lap = ~btn_lap;
`endif
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
